washing_machine_fill_controller: RTL and testbench

WASHING_MACHINE_FILL_CONTROLLER -- requirements
Module: washing_machine_fill_controller

---
 rtl/washing_machine_fill_controller_if.sv | 25 ++
 rtl/washing_machine_fill_controller.sv | 82 ++++++++
 tb/tb_washing_machine_fill_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/washing_machine_fill_controller_if.sv
// washing_machine_fill_controller_if: command, sensor and valve/status bundle of the fill controller
//   slave  (controller): start, target_level, sensor_level, drain_req, abort, clear_fault in;
//                        inlet_valve, drain_valve, fill_done, fault, state out
//   master (supervisor): the same signals with directions reversed
interface washing_machine_fill_controller_if;
  logic       start;
  logic [9:0] target_level;
  logic [9:0] sensor_level;
  logic       drain_req;
  logic       abort;
  logic       clear_fault;
  logic       inlet_valve;
  logic       drain_valve;
  logic       fill_done;
  logic       fault;
  logic [2:0] state;
  modport slave (
    input  start, target_level, sensor_level, drain_req, abort, clear_fault,
    output inlet_valve, drain_valve, fill_done, fault, state
  );
  modport master (
    output start, target_level, sensor_level, drain_req, abort, clear_fault,
    input  inlet_valve, drain_valve, fill_done, fault, state
  );
endinterface

// File: rtl/washing_machine_fill_controller.sv
// washing_machine_fill_controller: fills the tub to a target level, settles, holds done, drains
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : washing_machine_fill_controller_if.slave (commands, sensor, valves, status)
//   `define FILL_TIMEOUT_EN to include the fill timeout counter and the FILL->FAULT path
module washing_machine_fill_controller #(
  parameter logic [15:0] FILL_TIMEOUT_CYCLES = 16'd1000,
  parameter logic [7:0]  SETTLE_CYCLES       = 8'd8,
  parameter logic [9:0]  HYSTERESIS          = 10'd5
) (
  input logic clk,
  input logic reset,
  washing_machine_fill_controller_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    SETTLE = 3'd2,
    DONE   = 3'd3,
    DRAIN  = 3'd4,
    FAULT  = 3'd5
  } state_t;
  state_t     state_q, state_d;
  logic [9:0] target_q;
  logic [7:0] settle_q;
  logic       timeout;
  logic       reached;
  logic       drop;
  logic       settled;
`ifdef FILL_TIMEOUT_EN
  logic [15:0] timeout_q;
  assign timeout = timeout_q == FILL_TIMEOUT_CYCLES - 16'd1;
`else
  localparam logic [15:0] unused_timeout_cycles = FILL_TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  assign reached = bus.sensor_level >= target_q;
  // widened by one bit so sensor + hysteresis cannot wrap near full scale
  assign drop    = ({1'b0, bus.sensor_level} + {1'b0, HYSTERESIS}) < {1'b0, target_q};
  assign settled = settle_q == SETTLE_CYCLES - 8'd1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? (bus.target_level == 10'd0 ? DONE : FILL) : IDLE;
      FILL:    state_d = bus.abort ? DRAIN : reached ? SETTLE : timeout ? FAULT : FILL;
      SETTLE:  state_d = bus.abort ? DRAIN : drop ? FILL : settled ? DONE : SETTLE;
      DONE:    state_d = (bus.abort || bus.drain_req) ? DRAIN : DONE;
      DRAIN:   state_d = bus.sensor_level == 10'd0 ? IDLE : DRAIN;
      FAULT:   state_d = bus.abort ? DRAIN : bus.clear_fault ? IDLE : FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      settle_q <= '0;
`ifdef FILL_TIMEOUT_EN
      timeout_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      // settle count restarts on every entry to SETTLE, including after a refill
      settle_q <= state_q == SETTLE ? settle_q + 8'd1 : '0;
      if (state_q == IDLE && bus.start) target_q <= bus.target_level;
`ifdef FILL_TIMEOUT_EN
      // runs across SETTLE->FILL refills; only a new start resets it
      if (state_q == IDLE && bus.start) timeout_q <= '0;
      else if (state_q == FILL) timeout_q <= timeout_q + 16'd1;
`endif
    end
  end
  assign bus.inlet_valve = state_q == FILL;
  assign bus.drain_valve = state_q == DRAIN;
  assign bus.fill_done   = state_q == DONE;
`ifdef FILL_TIMEOUT_EN
  assign bus.fault       = state_q == FAULT;
`else
  assign bus.fault       = 1'b0;
`endif
  assign bus.state       = state_q;
endmodule

// File: tb/tb_washing_machine_fill_controller.sv
// tb_washing_machine_fill_controller: vector table with expected-state scoreboard plus corner sequences
module tb_washing_machine_fill_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  washing_machine_fill_controller_if bus();
  washing_machine_fill_controller #(.FILL_TIMEOUT_CYCLES(16'd40)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef struct {
    logic       start;
    logic [9:0] tgt;
    logic [9:0] sen;
    logic       drq;
    logic       ab;
    logic       clr;
    logic [2:0] st;
  } vec_t;
  vec_t       tbl[$];
  logic [2:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n;
  function automatic vec_t mk(logic s, int t, int l, logic d, logic a, logic c, int st);
    vec_t v;
    v.start = s; v.tgt = 10'(t); v.sen = 10'(l); v.drq = d; v.ab = a; v.clr = c; v.st = 3'(st);
    return v;
  endfunction
  function automatic int want(logic [2:0] s);
    return int'({s == 3'd1, s == 3'd4, s == 3'd3, s == 3'd5, s});
  endfunction
  function automatic int obs();
    return int'({bus.inlet_valve, bus.drain_valve, bus.fill_done, bus.fault, bus.state});
  endfunction
  function automatic void check(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endfunction
  task automatic drive(logic s, int t, int l, logic d, logic a, logic c);
    bus.start = s; bus.target_level = 10'(t); bus.sensor_level = 10'(l);
    bus.drain_req = d; bus.abort = a; bus.clear_fault = c;
  endtask
  task automatic step(string nm, vec_t v);
    @(negedge clk);
    drive(v.start, v.tgt, v.sen, v.drq, v.ab, v.clr);
    exp_q.push_back(v.st);
    @(posedge clk);
    #1;
    check(nm, obs(), want(exp_q.pop_front()));
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", obs(), want(3'd0));
    @(negedge clk);
    reset = 1'b1;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 50, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 20, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 50, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 50, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 45, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 44, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 50, 0, 0, 0, 2));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 50, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 50, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 50, 0, 0, 0, 3));
    tbl.push_back(mk(1, 100, 50, 1, 0, 0, 4));
    tbl.push_back(mk(1, 100, 10, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 300, 150, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 150, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 300, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 300, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 296, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 294, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1023, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1023, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1020, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1020, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);
    @(negedge clk);
    drive(1, 300, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.state == 3'd1 && n < 100) begin
      n++;
      bus.sensor_level = bus.sensor_level >= 10'd290 ? 10'd300 : bus.sensor_level + 10'd10;
      @(posedge clk);
      #1;
    end
    check("ramp_fill_cycles", n, 30);
    n = 0;
    while (bus.state == 3'd2 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("ramp_settle_cycles", n, 8);
    check("ramp_done", obs(), want(3'd3));
    step("ramp_drain", mk(0, 0, 300, 1, 0, 0, 4));
    step("ramp_drain_hold", mk(0, 0, 300, 0, 0, 0, 4));
    step("ramp_idle", mk(0, 0, 0, 0, 0, 0, 0));
`ifdef FILL_TIMEOUT_EN
    step("to_start", mk(1, 100, 0, 0, 0, 0, 1));
    bus.start = 1'b0;
    n = 0;
    while (bus.state == 3'd1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("to_fill_cycles", n, 40);
    check("to_fault", obs(), want(3'd5));
    step("to_hold", mk(1, 100, 0, 0, 0, 0, 5));
    step("to_clear", mk(0, 0, 0, 0, 0, 1, 0));
`else
    step("nto_start", mk(1, 100, 0, 0, 0, 0, 1));
    bus.start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("nto_still_fill", obs(), want(3'd1));
    step("nto_abort", mk(0, 0, 0, 0, 1, 0, 4));
    step("nto_idle", mk(0, 0, 0, 0, 0, 0, 0));
`endif
    step("rst_fill", mk(1, 500, 0, 0, 0, 0, 1));
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", obs(), want(3'd0));
    @(negedge clk);
    reset = 1'b1;
    drive(1, 500, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("rst_first_start", obs(), want(3'd1));
    step("rst_abort", mk(0, 0, 0, 0, 1, 0, 4));
    step("rst_idle", mk(0, 0, 0, 0, 0, 0, 0));
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
